// File: rtl/casc_3a_pkg.sv
`default_nettype none
// ============================================================================
// Module   : casc_3a_pkg
// Purpose  : OPMODE constants, FSM states and the OPMODE selector shared by
//            the cascaded DSP48 MAC sequencer.
// Revision : 1.0
// ============================================================================
package casc_3a_pkg;

  localparam logic [6:0] OPM_M_ZERO = 7'h05;
  localparam logic [6:0] OPM_M_C    = 7'h35;
  localparam logic [6:0] OPM_M_P17  = 7'h65;
  localparam logic [6:0] OPM_IDLE   = 7'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Row start adds the C word from the previous row, except row 0 which has none.
  function automatic logic [6:0] opm_sel(input logic first_row, input logic first_col);
    if (!first_col)
      return OPM_M_P17;
    else if (first_row)
      return OPM_M_ZERO;
    else
      return OPM_M_C;
  endfunction

endpackage
`default_nettype wire

// File: rtl/casc_3a_dly.sv
`default_nettype none
// ============================================================================
// Module   : casc_3a_dly
// Purpose  : DEPTH-stage, WIDTH-bit shift register, async reset to 0.
// Revision : 1.0
// ============================================================================
module casc_3a_dly #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic w_unused;
      assign w_unused = clk ^ rst;
      assign o_q = i_d;
    end else begin : g_shift
      logic [DEPTH-1:0][WIDTH-1:0] r_sr;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sr <= '0;
        end else begin
          r_sr[0] <= i_d;
          for (int k = 1; k < DEPTH; k++)
            r_sr[k] <= r_sr[k-1];
        end
      end

      assign o_q = r_sr[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/casc_3a_sched.sv
`default_nettype none
// ============================================================================
// Module   : casc_3a_sched
// Purpose  : Walks the S x S word-product schedule of one cascaded DSP48 MAC
//            slice, issuing operand indices and pipeline-aligned controls.
// Revision : 1.0
// ============================================================================
module casc_3a_sched
  import casc_3a_pkg::*;
#(
  parameter int ABREG = 1,
  parameter int MREG  = 1,
  parameter int S     = 8
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [$clog2(S)-1:0] a_idx_o,
  output logic [$clog2(S)-1:0] b_idx_o,
  output logic [6:0]           opmode_o,
  output logic                 creg_en_o,
  output logic                 p_valid_o,
  output logic [$clog2(S)-1:0] p_row_o,
  output logic [$clog2(S)-1:0] p_col_o
);

  localparam int             DSP_REG_LEVEL = 1 + ABREG + MREG;
  localparam int             OPM_DLY       = DSP_REG_LEVEL - 2;
  localparam int             IW            = $clog2(S);
  localparam logic [IW-1:0]  C_LAST        = IW'(S - 1);

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_i, r_j, w_i_nxt, w_j_nxt;
  logic            w_run, w_row_end, w_last_issue, w_done;
  logic [6:0]      w_opm_issue;
  logic [2*IW:0]   w_pv_d, w_pv_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_j     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_i     <= w_i_nxt;
      r_j     <= w_j_nxt;
    end
  end

  assign w_run        = (r_state == RUN);
  assign w_row_end    = (r_j == C_LAST);
  assign w_last_issue = w_run && w_row_end && (r_i == C_LAST);

  // Counters sit at zero outside RUN, so the index outputs need no masking.
  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = '0;
    w_j_nxt     = '0;
    case (r_state)
      IDLE: begin
        if (start_i)
          w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last_issue) begin
          w_state_nxt = DRAIN;
        end else if (w_row_end) begin
          w_i_nxt = r_i + 1'b1;
        end else begin
          w_i_nxt = r_i;
          w_j_nxt = r_j + 1'b1;
        end
      end
      DRAIN: begin
        if (w_done)
          w_state_nxt = start_i ? RUN : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_opm_issue = w_run ? opm_sel(r_i == '0, r_j == '0) : OPM_IDLE;
  assign w_pv_d      = {w_run, r_i, r_j};

  casc_3a_dly #(
    .DEPTH (OPM_DLY),
    .WIDTH (7)
  ) u_opm_dly (
    .clk (clock_i),
    .rst (reset_i),
    .i_d (w_opm_issue),
    .o_q (opmode_o)
  );

  casc_3a_dly #(
    .DEPTH (DSP_REG_LEVEL),
    .WIDTH (2*IW + 1)
  ) u_pv_dly (
    .clk (clock_i),
    .rst (reset_i),
    .i_d (w_pv_d),
    .o_q (w_pv_q)
  );

  assign p_valid_o = w_pv_q[2*IW];
  assign p_row_o   = w_pv_q[2*IW-1:IW];
  assign p_col_o   = w_pv_q[IW-1:0];

  assign w_done    = (r_state == DRAIN) && p_valid_o && (p_row_o == C_LAST) && (p_col_o == C_LAST);
  assign done_o    = w_done;
  assign busy_o    = (r_state != IDLE);
  assign a_idx_o   = r_i;
  assign b_idx_o   = r_j;
  assign creg_en_o = w_run && w_row_end && (r_i != C_LAST);

endmodule
`default_nettype wire

// File: tb/tb_casc_3a_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_casc_3a_sched
// Purpose  : Directed self-checking bench for casc_3a_sched (S=4 L=3, S=2 L=2).
// Revision : 1.0
// ============================================================================
module tb_casc_3a_sched;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       start1, start2;

  logic       busy1, done1, creg1, pv1;
  logic [1:0] a1, b1, pr1, pc1;
  logic [6:0] opm1;

  logic       busy2, done2, creg2, pv2;
  logic [0:0] a2, b2, pr2, pc2;
  logic [6:0] opm2;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clock_i = ~clock_i;

  casc_3a_sched #(.ABREG(1), .MREG(1), .S(4)) dut (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .start_i   (start1),
    .busy_o    (busy1),
    .done_o    (done1),
    .a_idx_o   (a1),
    .b_idx_o   (b1),
    .opmode_o  (opm1),
    .creg_en_o (creg1),
    .p_valid_o (pv1),
    .p_row_o   (pr1),
    .p_col_o   (pc1)
  );

  casc_3a_sched #(.ABREG(0), .MREG(1), .S(2)) dut2 (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .start_i   (start2),
    .busy_o    (busy2),
    .done_o    (done2),
    .a_idx_o   (a2),
    .b_idx_o   (b2),
    .opmode_o  (opm2),
    .creg_en_o (creg2),
    .p_valid_o (pv2),
    .p_row_o   (pr2),
    .p_col_o   (pc2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
    cyc++;
  endtask

  // Expected outputs in cycle c after a start sampled at edge 0 (c<=0: idle).
  task automatic check_cycle(input string p, input int c, input int s, input int l,
                             input logic [31:0] busy, input logic [31:0] done,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] opm, input logic [31:0] creg,
                             input logic [31:0] pv, input logic [31:0] pr,
                             input logic [31:0] pc);
    int ss, co, cp;
    logic [31:0] e_a, e_b, e_opm, e_creg, e_pv, e_pr, e_pc;
    ss = s * s;
    e_a = 0; e_b = 0; e_creg = 0; e_opm = 0; e_pv = 0; e_pr = 0; e_pc = 0;
    if (c >= 1 && c <= ss) begin
      e_a    = (c - 1) / s;
      e_b    = (c - 1) % s;
      e_creg = (e_b == s - 1 && e_a < s - 1) ? 1 : 0;
    end
    co = c - (l - 2);
    if (co >= 1 && co <= ss)
      e_opm = (co == 1) ? 32'h05 : (((co - 1) % s == 0) ? 32'h35 : 32'h65);
    cp = c - l;
    if (cp >= 1 && cp <= ss) begin
      e_pv = 1;
      e_pr = (cp - 1) / s;
      e_pc = (cp - 1) % s;
    end
    check($sformatf("%s_c%0d_busy", p, c), busy, (c >= 1 && c <= ss + l) ? 1 : 0);
    check($sformatf("%s_c%0d_done", p, c), done, (c == ss + l) ? 1 : 0);
    check($sformatf("%s_c%0d_aidx", p, c), a, e_a);
    check($sformatf("%s_c%0d_bidx", p, c), b, e_b);
    check($sformatf("%s_c%0d_opm", p, c), opm, e_opm);
    check($sformatf("%s_c%0d_creg", p, c), creg, e_creg);
    check($sformatf("%s_c%0d_pvld", p, c), pv, e_pv);
    check($sformatf("%s_c%0d_prow", p, c), pr, e_pr);
    check($sformatf("%s_c%0d_pcol", p, c), pc, e_pc);
  endtask

  task automatic chk1(input string p, input int c);
    check_cycle(p, c, 4, 3, busy1, done1, a1, b1, opm1, creg1, pv1, pr1, pc1);
  endtask

  task automatic chk2(input string p, input int c);
    check_cycle(p, c, 2, 2, busy2, done2, a2, b2, opm2, creg2, pv2, pr2, pc2);
  endtask

  task automatic run_a(input string p, input bit pulses);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      if (c > 1) step();
      start1 = pulses && (c == 5 || c == 10);
      chk1(p, c);
      if (c == 2) check({p, "_opm_first"}, opm1, 32'h05);
      if (c == 6) check({p, "_opm_row1"}, opm1, 32'h35);
      if (c == 10) begin
        check({p, "_row_c10"}, pr1, 1);
        check({p, "_col_c10"}, pc1, 2);
      end
      if (c == 19) check({p, "_done_c19"}, done1, 1);
    end
    start1 = 1'b0;
  endtask

  initial begin
    int base, rel;
    reset_i = 1'b1;
    start1  = 1'b0;
    start2  = 1'b0;
    step();
    step();
    chk1("reset", 0);
    chk2("reset2", 0);
    reset_i = 1'b0;
    step();
    chk1("idle", 0);

    run_a("basic", 1'b0);
    run_a("pulse", 1'b1);

    // start held high: second run follows the done cycle with no gap
    start1 = 1'b1;
    base   = cyc;
    for (int k = 0; k < 41; k++) begin
      step();
      rel = cyc - base;
      if (rel == 21) start1 = 1'b0;
      chk1("b2b", (rel <= 19) ? rel : rel - 19);
      if (rel == 20) check("b2b_c20_aidx0_busy", busy1, 1);
    end
    start1 = 1'b0;

    // asynchronous reset in cycle 7
    base   = cyc;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk1("rst", 1);
    while (cyc - base < 7) begin
      step();
      chk1("rst", cyc - base);
    end
    #2 reset_i = 1'b1;
    #1 chk1("rst_async", 0);
    step();
    chk1("rst_hold", 0);
    reset_i = 1'b0;
    repeat (25) begin
      step();
      chk1("rst_after", 0);
    end
    run_a("post_rst", 1'b0);

    // S=2, ABREG=0 instance
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) step();
      chk2("s2", c);
      if (c == 6) check("s2_done_c6", done2, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
